// File: rtl/apb_slave_mem.sv
// APB4 completer backed by a DEPTH x 32-bit register file, with fixed wait states and error responses.
// Optional build macro APB_SLAVE_MEM_PROT_CHECK_EN rejects unprivileged writes to the upper half of storage.
module apb_slave_mem #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [3:0]  PSTRB,
  input  logic [2:0]  PPROT,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            write_q, write_d;
  logic [3:0]      strb_q, strb_d;
  logic            err_q, err_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            pready_q, pready_d;
  logic            pslverr_q, pslverr_d;
  logic [31:0]     prdata_q, prdata_d;
  logic [31:0]     mem_q [DEPTH];

  logic [29:0]     word_s;
  logic            err_s;
  logic            prot_err_s;
  logic            raise_s;
  logic            commit_s;
  logic [31:0]     wr_word_s;
  logic            unused_s;

  assign unused_s = ^PPROT;

  // Error classification of the address/control presented in the setup phase
  always_comb begin
    word_s = PADDR[31:2];
`ifdef APB_SLAVE_MEM_PROT_CHECK_EN
    prot_err_s = PWRITE && !PPROT[0] && word_s[AW-1];
`else
    prot_err_s = 1'b0;
`endif
    err_s = (PADDR[1:0] != 2'b00) || (word_s >= 30'(DEPTH)) || prot_err_s;
  end

  // Transfer sequencing, wait counting and response generation
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    write_d   = write_q;
    strb_d    = strb_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = 32'h0000_0000;
    raise_s   = 1'b0;
    commit_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          idx_d   = word_s[AW-1:0];
          write_d = PWRITE;
          strb_d  = PSTRB;
          err_d   = err_s;
          cnt_d   = 4'(WAIT_STATES);
          raise_s = (4'(WAIT_STATES) == 4'd0);
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (PENABLE && pready_q) begin
          state_d  = IDLE;
          commit_s = write_q && !err_q;
        end else if (PENABLE) begin
          // The decrement that reaches zero is the edge that raises PREADY
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            cnt_d = cnt_q;
          end
          raise_s = (cnt_q <= 4'd1);
        end else begin
          pready_d  = pready_q;
          pslverr_d = pslverr_q;
          prdata_d  = prdata_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (raise_s) begin
      pready_d  = 1'b1;
      pslverr_d = err_d;
      prdata_d  = (!write_d && !err_d) ? mem_q[idx_d] : 32'h0000_0000;
    end else begin
      raise_s = 1'b0;
    end
  end

  // Byte-lane merge of the write data into the addressed word
  always_comb begin
    wr_word_s = mem_q[idx_q];
    for (int i = 0; i < 4; i++) begin
      if (strb_q[i]) begin
        wr_word_s[8*i +: 8] = PWDATA[8*i +: 8];
      end else begin
        wr_word_s[8*i +: 8] = mem_q[idx_q][8*i +: 8];
      end
    end
  end

  // State, response and storage registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      write_q   <= 1'b0;
      strb_q    <= 4'h0;
      err_q     <= 1'b0;
      cnt_q     <= 4'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= 32'h0000_0000;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      strb_q    <= strb_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      if (commit_s) begin
        mem_q[idx_q] <= wr_word_s;
      end
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: one instance with no wait states, one with three.
module tb_apb_slave_mem;

  logic        PCLK;
  logic        PRESETn;
  logic        sel0, sel3;
  logic        PENABLE;
  logic        PWRITE;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3;
  logic        pslverr0, pslverr3;

  int total  = 0;
  int passed = 0;

  apb_slave_mem #(.DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(sel0), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PSTRB(PSTRB), .PPROT(PPROT), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
  );

  apb_slave_mem #(.DEPTH(256), .WAIT_STATES(3)) u_dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(sel3), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PSTRB(PSTRB), .PPROT(PPROT), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One full transfer on the chosen instance; waits = access cycles seen with PREADY low
  task automatic xfer(input bit d3, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot,
                      output logic [31:0] rd, output logic err, output int waits);
    logic rdy;
    @(negedge PCLK);
    sel0 = !d3; sel3 = d3; PENABLE = 1'b0;
    PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb; PPROT = prot;
    @(negedge PCLK);
    PENABLE = 1'b1;
    waits = 0;
    rdy = d3 ? pready3 : pready0;
    while (!rdy && waits < 40) begin
      waits++;
      @(negedge PCLK);
      rdy = d3 ? pready3 : pready0;
    end
    chk("ready", {31'd0, rdy}, 32'd1);
    rd  = d3 ? prdata3 : prdata0;
    err = d3 ? pslverr3 : pslverr0;
    @(negedge PCLK);
    sel0 = 1'b0; sel3 = 1'b0; PENABLE = 1'b0;
    rdy = d3 ? pready3 : pready0;
    chk("pulse_one_cycle", {31'd0, rdy}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        err;
  int          waits;

  initial begin
    PRESETn = 1'b0; sel0 = 1'b0; sel3 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PSTRB = 4'h0; PPROT = 3'b000; PADDR = 32'h0; PWDATA = 32'h0;
    #23;
    chk("rst_pready",  {31'd0, pready0},  32'd0);
    chk("rst_pslverr", {31'd0, pslverr0}, 32'd0);
    chk("rst_prdata",  prdata0,           32'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // stray PENABLE in IDLE is ignored
    @(negedge PCLK); sel0 = 1'b1; PENABLE = 1'b1;
    @(negedge PCLK); chk("stray_enable", {31'd0, pready0}, 32'd0);
    sel0 = 1'b0; PENABLE = 1'b0;

    xfer(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b000, rd, err, waits);
    chk("wr_ws0_waits", waits, 32'd0);
    chk("wr_ws0_err", {31'd0, err}, 32'd0);
    xfer(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, err, waits);
    chk("rd_ws0_waits", waits, 32'd0);
    chk("rd_ws0_data", rd, 32'hDEAD_BEEF);

    xfer(1'b0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 3'b000, rd, err, waits);
    xfer(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000, rd, err, waits);
    chk("partial_data", rd, 32'hDE22_BE44);

    xfer(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, err, waits);
    chk("rd_ws3_waits", waits, 32'd3);
    chk("rd_ws3_data", rd, 32'h0);
    chk("rd_ws3_err", {31'd0, err}, 32'd0);

    xfer(1'b0, 1'b0, 32'h402, 32'h0, 4'h0, 3'b001, rd, err, waits);
    chk("misalign_err", {31'd0, err}, 32'd1);
    chk("misalign_data", rd, 32'h0);

    xfer(1'b0, 1'b1, 32'h400, 32'h1234_5678, 4'hF, 3'b001, rd, err, waits);
    chk("oor_wr_err", {31'd0, err}, 32'd1);
    xfer(1'b0, 1'b0, 32'h400, 32'h0, 4'h0, 3'b001, rd, err, waits);
    chk("oor_rd_err", {31'd0, err}, 32'd1);
    chk("oor_rd_data", rd, 32'h0);
    xfer(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, err, waits);
    chk("oor_no_alias", rd, 32'h0);

`ifdef APB_SLAVE_MEM_PROT_CHECK_EN
    xfer(1'b0, 1'b1, 32'h320, 32'hA5A5_0001, 4'hF, 3'b000, rd, err, waits);
    chk("prot_unpriv_err", {31'd0, err}, 32'd1);
    xfer(1'b0, 1'b0, 32'h320, 32'h0, 4'h0, 3'b000, rd, err, waits);
    chk("prot_unpriv_data", rd, 32'h0);
    xfer(1'b0, 1'b1, 32'h320, 32'hA5A5_0001, 4'hF, 3'b001, rd, err, waits);
    chk("prot_priv_err", {31'd0, err}, 32'd0);
`else
    xfer(1'b0, 1'b1, 32'h320, 32'hA5A5_0001, 4'hF, 3'b000, rd, err, waits);
    chk("noprot_err", {31'd0, err}, 32'd0);
`endif
    xfer(1'b0, 1'b0, 32'h320, 32'h0, 4'h0, 3'b000, rd, err, waits);
`ifdef APB_SLAVE_MEM_PROT_CHECK_EN
    chk("upper_data", rd, 32'hA5A5_0001);
`else
    chk("upper_data", rd, 32'hA5A5_0001);
`endif

    // abort a WAIT_STATES=3 write in its second access cycle
    xfer(1'b1, 1'b1, 32'h20, 32'h55AA_55AA, 4'hF, 3'b000, rd, err, waits);
    chk("prior_wr_waits", waits, 32'd3);
    @(negedge PCLK);
    sel3 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h20; PWDATA = 32'hCAFE_F00D; PSTRB = 4'hF;
    @(negedge PCLK); PENABLE = 1'b1;
    chk("abort_t1_pready", {31'd0, pready3}, 32'd0);
    @(negedge PCLK); sel3 = 1'b0; PENABLE = 1'b0;
    chk("abort_t2_pready", {31'd0, pready3}, 32'd0);
    @(negedge PCLK);
    chk("abort_after_pready", {31'd0, pready3}, 32'd0);
    xfer(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000, rd, err, waits);
    chk("abort_readback", rd, 32'h55AA_55AA);

    // async reset while the no-wait write to 0x30 shows PREADY
    @(negedge PCLK);
    sel0 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h30; PWDATA = 32'h7777_7777; PSTRB = 4'hF;
    @(negedge PCLK); PENABLE = 1'b1;
    chk("pre_reset_pready", {31'd0, pready0}, 32'd1);
    #2 PRESETn = 1'b0;
    #1;
    chk("async_pready",  {31'd0, pready0},  32'd0);
    chk("async_pslverr", {31'd0, pslverr0}, 32'd0);
    chk("async_prdata",  prdata0,           32'h0);
    sel0 = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK); PRESETn = 1'b1;
    xfer(1'b0, 1'b0, 32'h30, 32'h0, 4'h0, 3'b000, rd, err, waits);
    chk("reset_discard_wr", rd, 32'h0);
    xfer(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, err, waits);
    chk("reset_clears_mem", rd, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
